exc_irq_controller: RTL and testbench

EXC_IRQ_CONTROLLER -- requirements
Module: exc_irq_controller

---
 rtl/exc_irq_pkg.sv | 14 +
 rtl/irq_sync.sv | 28 ++
 rtl/exc_irq_controller.sv | 148 ++++++++++++++
 tb/tb_exc_irq_controller.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exc_irq_pkg.sv
// Shared types for the external-interrupt controller.
//   irqStateT : controller FSM states
//     IDLE    - no transaction, arbitrating every cycle
//     REQ     - ExtIRQ asserted, waiting for the core's ExcAck
//     SERVICE - handler running, waiting for ERet
package exc_irq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irqStateT;

endpackage

// File: rtl/irq_sync.sv
// Two-flop synchronizer bank for asynchronous interrupt inputs.
// Ports:
//   clk     - destination clock
//   reset   - asynchronous active-low reset, clears both stages
//   asyncIn - WIDTH asynchronous inputs
//   synced  - WIDTH inputs after two flops in the clk domain
module irq_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] asyncIn,
  output logic [WIDTH-1:0] synced
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta   <= '0;
      synced <= '0;
    end else begin
      meta   <= asyncIn;
      synced <= meta;
    end
  end

endmodule

// File: rtl/exc_irq_controller.sv
// External interrupt controller: synchronizes NUM_IRQ sources, keeps a
// pending register (edge- or level-triggered per channel), arbitrates the
// enabled pending channels (fixed priority or round-robin) and runs a
// single, non-nesting request/acknowledge/return transaction with the core.
//
// Ports:
//   clk, reset  - clock, asynchronous active-low reset
//   irq_in      - asynchronous interrupt sources
//   mask_we     - mask write strobe, mask_wdata is the new enable mask
//   ExcAck      - core has entered the handler
//   ERet        - core executed ERET
//   ExtIRQ      - registered interrupt request to the core
//   irq_id      - channel being requested / serviced
//   ExtlAck     - one-hot, one-cycle acknowledge back to the source
//   pending     - pending register
//   busy        - high in REQ and SERVICE
//   dbgState    - current FSM state, for observation only
//
// Handshake: ExtIRQ rises when a channel is granted and stays high with a
// frozen irq_id until ExcAck is sampled high; that same edge drops ExtIRQ,
// pulses ExtlAck[irq_id] and enters SERVICE. ERet sampled high in SERVICE
// ends the transaction. ExcAck outside REQ and ERet outside SERVICE are
// ignored.
module exc_irq_controller
  import exc_irq_pkg::*;
#(
  parameter int                 NUM_IRQ   = 4,
  parameter int                 ID_W      = 4,
  parameter int                 RR_MODE   = 0,
  parameter logic [NUM_IRQ-1:0] EDGE_MASK = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  input  logic               ExcAck,
  input  logic               ERet,
  output logic               ExtIRQ,
  output logic [ID_W-1:0]    irq_id,
  output logic [NUM_IRQ-1:0] ExtlAck,
  output logic [NUM_IRQ-1:0] pending,
  output logic               busy,
  output irqStateT           dbgState
);

  localparam logic [NUM_IRQ-1:0] ONE_HOT0 = NUM_IRQ'(1);

  irqStateT             state;
  logic [NUM_IRQ-1:0]   irqSync;
  logic [NUM_IRQ-1:0]   irqPrev;
  logic [NUM_IRQ-1:0]   maskReg;
  logic [NUM_IRQ-1:0]   rise;
  logic [NUM_IRQ-1:0]   clrVec;
  logic [NUM_IRQ-1:0]   eligible;
  logic [ID_W-1:0]      rrPtr;
  logic [ID_W-1:0]      nextPtr;
  logic [ID_W-1:0]      winId;
  logic                 winValid;
  logic [2*NUM_IRQ-1:0] rotated;
  int                   offset;
  int                   winSum;

  irq_sync #(.WIDTH(NUM_IRQ)) uSync (
    .clk     (clk),
    .reset   (reset),
    .asyncIn (irq_in),
    .synced  (irqSync)
  );

  assign rise     = irqSync & ~irqPrev;
  assign clrVec   = (state == REQ && ExcAck) ? (ONE_HOT0 << irq_id) : '0;
  assign eligible = pending & maskReg;
  assign nextPtr  = (irq_id == ID_W'(NUM_IRQ - 1)) ? '0 : irq_id + ID_W'(1);
  assign busy     = (state != IDLE);
  assign dbgState = state;

  // Edge channels: a fresh rising edge wins over a same-cycle clear, so the
  // set term is ORed in after the clear. Level channels follow the
  // synchronized input one cycle later and ignore clears.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irqPrev <= '0;
      pending <= '0;
      maskReg <= '1;
    end else begin
      irqPrev <= irqSync;
      pending <= (EDGE_MASK & (rise | (pending & ~clrVec))) |
                 (~EDGE_MASK & irqSync);
      if (mask_we) maskReg <= mask_wdata;
    end
  end

  // Rotate eligible so the search starts at rrPtr; the first set bit of the
  // low half is the distance to the winner. In fixed-priority mode rrPtr
  // never leaves 0, so this degenerates to lowest-index-first.
  always_comb begin
    rotated  = {eligible, eligible} >> rrPtr;
    winValid = 1'b0;
    offset   = 0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        winValid = 1'b1;
        offset   = i;
      end
    end
    winSum = int'(rrPtr) + offset;
    if (winSum >= NUM_IRQ) winSum = winSum - NUM_IRQ;
    winId = ID_W'(winSum);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      ExtIRQ  <= 1'b0;
      irq_id  <= '0;
      ExtlAck <= '0;
      rrPtr   <= '0;
    end else begin
      ExtlAck <= '0;
      case (state)
        IDLE: begin
          if (winValid) begin
            irq_id <= winId;
            ExtIRQ <= 1'b1;
            state  <= REQ;
          end
        end
        REQ: begin
          // The grant is committed: mask or pending changes do not retract it.
          if (ExcAck) begin
            ExtIRQ  <= 1'b0;
            ExtlAck <= ONE_HOT0 << irq_id;
            state   <= SERVICE;
          end
        end
        SERVICE: begin
          if (ERet) begin
            state <= IDLE;
            if (RR_MODE != 0) rrPtr <= nextPtr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exc_irq_controller.sv
`timescale 1ns/1ps
module tb_exc_irq_controller;
  import exc_irq_pkg::*;

  localparam logic [3:0] EDGE0 = 4'b0101;  // fixed-priority instance
  localparam logic [3:0] EDGE1 = 4'b1010;  // round-robin instance

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstN;
  always #5 clk = ~clk;

  logic [3:0] irqIn[2], maskWdata[2], ackOut[2], pendOut[2], idOut[2];
  logic       maskWe[2], excAck[2], eRet[2], extIrq[2], busyOut[2];
  irqStateT   dbg[2];

  exc_irq_controller #(.NUM_IRQ(4), .ID_W(4), .RR_MODE(0), .EDGE_MASK(EDGE0)) uFix (
    .clk(clk), .reset(rstN), .irq_in(irqIn[0]), .mask_we(maskWe[0]),
    .mask_wdata(maskWdata[0]), .ExcAck(excAck[0]), .ERet(eRet[0]),
    .ExtIRQ(extIrq[0]), .irq_id(idOut[0]), .ExtlAck(ackOut[0]),
    .pending(pendOut[0]), .busy(busyOut[0]), .dbgState(dbg[0])
  );

  exc_irq_controller #(.NUM_IRQ(4), .ID_W(4), .RR_MODE(1), .EDGE_MASK(EDGE1)) uRr (
    .clk(clk), .reset(rstN), .irq_in(irqIn[1]), .mask_we(maskWe[1]),
    .mask_wdata(maskWdata[1]), .ExcAck(excAck[1]), .ERet(eRet[1]),
    .ExtIRQ(extIrq[1]), .irq_id(idOut[1]), .ExtlAck(ackOut[1]),
    .pending(pendOut[1]), .busy(busyOut[1]), .dbgState(dbg[1])
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [3:0] expId0[$], expId1[$], expAck0[$], expAck1[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, wanted %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name, input logic [3:0] act);
    total++;
    bad++;
    $display("FAIL %s: got %0h, wanted nothing (t=%0t)", name, act, $time);
  endtask

  task automatic pushId(input int d, input int v);
    if (d == 0) expId0.push_back(4'(v)); else expId1.push_back(4'(v));
  endtask

  task automatic pushAck(input int d, input int v);
    logic [3:0] oh;
    oh = 4'b0001 << v;
    if (d == 0) expAck0.push_back(oh); else expAck1.push_back(oh);
  endtask

  // ---------------- monitor ----------------
  logic prevExt[2];
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (extIrq[d] && !prevExt[d]) begin
        if (d == 0) begin
          if (expId0.size() == 0) unexpected("dut0 request", idOut[0]);
          else check("dut0 request id", idOut[0], expId0.pop_front());
        end else begin
          if (expId1.size() == 0) unexpected("dut1 request", idOut[1]);
          else check("dut1 request id", idOut[1], expId1.pop_front());
        end
      end
      if (ackOut[d] != 4'b0) begin
        if (d == 0) begin
          if (expAck0.size() == 0) unexpected("dut0 ack", ackOut[0]);
          else check("dut0 ack", ackOut[0], expAck0.pop_front());
        end else begin
          if (expAck1.size() == 0) unexpected("dut1 ack", ackOut[1]);
          else check("dut1 ack", ackOut[1], expAck1.pop_front());
        end
      end
      prevExt[d] <= extIrq[d];
    end
  end

  // ---------------- reference model ----------------
  // The model tracks what the bench has driven: latched edge requests,
  // the current input pattern, the mask and the round-robin start point.
  logic [3:0] mEdgePend[2], mMask[2], mCur[2];
  int         mRr[2];

  function automatic logic [3:0] edgeOf(input int d);
    return (d == 0) ? EDGE0 : EDGE1;
  endfunction

  function automatic logic [3:0] eligibleNow(input int d);
    return (mEdgePend[d] | (mCur[d] & ~edgeOf(d))) & mMask[d];
  endfunction

  function automatic int pick(input logic [3:0] set, input int ptr);
    for (int off = 0; off < 4; off++)
      if (set[(ptr + off) % 4]) return (ptr + off) % 4;
    return -1;
  endfunction

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      mEdgePend[d] = 4'b0;
      mMask[d]     = 4'b1111;
      mCur[d]      = 4'b0;
      mRr[d]       = 0;
    end
  endtask

  // ---------------- drivers (called at a negedge) ----------------
  task automatic driveIrq(input int d, input logic [3:0] p);
    mEdgePend[d] = mEdgePend[d] | (p & ~mCur[d] & edgeOf(d));
    mCur[d]      = p;
    irqIn[d]     = p;
  endtask

  task automatic startTxn(input int d, input logic [3:0] p, output int nxt);
    @(negedge clk);
    driveIrq(d, p);
    nxt = pick(eligibleNow(d), mRr[d]);
    if (nxt >= 0) pushId(d, nxt);
    else repeat (5) @(negedge clk);
  endtask

  task automatic writeMask(input int d, input logic [3:0] m, output int nxt);
    maskWe[d]    = 1'b1;
    maskWdata[d] = m;
    mMask[d]     = m;
    nxt = pick(eligibleNow(d), mRr[d]);
    if (nxt >= 0) pushId(d, nxt);
    @(negedge clk);
    maskWe[d] = 1'b0;
  endtask

  task automatic ackPhase(input int d, input int win);
    int cnt;
    cnt = 0;
    while (!extIrq[d] && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check($sformatf("dut%0d request within budget", d), extIrq[d], 1'b1);
    if (!extIrq[d]) return;
    repeat ($urandom_range(0, 3)) @(negedge clk);
    excAck[d] = 1'b1;
    pushAck(d, win);
    @(negedge clk);
    excAck[d] = 1'b0;
    mEdgePend[d] = mEdgePend[d] & ~(4'b0001 << win);
  endtask

  task automatic eretPhase(input int d, input int win, input bit lower, output int nxt);
    if (lower) driveIrq(d, 4'b0);
    repeat (5) @(negedge clk);
    if (d == 1) mRr[d] = (win + 1) % 4;
    nxt = pick(eligibleNow(d), mRr[d]);
    if (nxt >= 0) pushId(d, nxt);
    eRet[d] = 1'b1;
    @(negedge clk);
    eRet[d] = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int nxt, guard;
    for (int d = 0; d < 2; d++) begin
      irqIn[d] = 4'b0; maskWe[d] = 1'b0; maskWdata[d] = 4'b0;
      excAck[d] = 1'b0; eRet[d] = 1'b0; prevExt[d] = 1'b0;
    end
    modelReset();
    rstN = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("dut%0d reset ExtIRQ", d), extIrq[d], 1'b0);
      check($sformatf("dut%0d reset irq_id", d), idOut[d], 4'd0);
      check($sformatf("dut%0d reset ExtlAck", d), ackOut[d], 4'd0);
      check($sformatf("dut%0d reset pending", d), pendOut[d], 4'd0);
      check($sformatf("dut%0d reset busy", d), busyOut[d], 1'b0);
    end
    rstN = 1'b1;
    repeat (2) @(negedge clk);

    // Two channels at once, fixed priority: latency and one-cycle ack.
    driveIrq(0, 4'b0110);
    pushId(0, pick(eligibleNow(0), 0));
    repeat (3) @(negedge clk);
    check("latency pending k+2", pendOut[0], 4'b0110);
    check("latency ExtIRQ low k+2", extIrq[0], 1'b0);
    @(negedge clk);
    check("latency ExtIRQ high k+3", extIrq[0], 1'b1);
    check("fixed winner", idOut[0], 4'd1);
    check("busy in REQ", busyOut[0], 1'b1);
    excAck[0] = 1'b1;
    pushAck(0, 1);
    @(negedge clk);
    excAck[0] = 1'b0;
    check("ack pulse", ackOut[0], 4'b0010);
    check("ExtIRQ drop on ack", extIrq[0], 1'b0);
    check("state SERVICE", dbg[0], SERVICE);
    @(negedge clk);
    check("ack one cycle", ackOut[0], 4'b0000);
    excAck[0] = 1'b1;  // ignored in SERVICE
    @(negedge clk);
    excAck[0] = 1'b0;
    check("ExcAck ignored in SERVICE", dbg[0], SERVICE);
    eretPhase(0, 1, 1'b1, nxt);
    while (nxt >= 0) begin
      ackPhase(0, nxt);
      eretPhase(0, nxt, 1'b1, nxt);
    end

    // Stray ExcAck in IDLE, stray ERet in REQ.
    excAck[0] = 1'b1;
    @(negedge clk);
    excAck[0] = 1'b0;
    @(negedge clk);
    check("ExcAck ignored in IDLE", dbg[0], IDLE);
    check("no busy after stray ack", busyOut[0], 1'b0);
    startTxn(0, 4'b0001, nxt);
    guard = 0;
    while (!extIrq[0] && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    eRet[0] = 1'b1;
    @(negedge clk);
    eRet[0] = 1'b0;
    check("ERet ignored in REQ", dbg[0], REQ);
    check("ExtIRQ held through ERet", extIrq[0], 1'b1);
    ackPhase(0, nxt);
    eretPhase(0, nxt, 1'b1, nxt);

    // Masked edge pulse stays latched; unmasking issues the request.
    writeMask(0, 4'b1110, nxt);
    driveIrq(0, 4'b0001);
    @(negedge clk);
    driveIrq(0, 4'b0000);
    repeat (6) @(negedge clk);
    check("masked no request", extIrq[0], 1'b0);
    check("masked edge latched", pendOut[0], 4'b0001);
    writeMask(0, 4'b1111, nxt);
    check("unmask not yet applied", extIrq[0], 1'b0);
    @(negedge clk);
    check("unmask request", extIrq[0], 1'b1);
    ackPhase(0, nxt);
    eretPhase(0, nxt, 1'b1, nxt);

    // Edge channel 2 re-fires on the same edge as its ExcAck.
    startTxn(0, 4'b0100, nxt);
    @(negedge clk);
    driveIrq(0, 4'b0000);
    guard = 0;
    while (!extIrq[0] && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("ch2 requested", extIrq[0], 1'b1);
    driveIrq(0, 4'b0100);
    @(negedge clk);
    driveIrq(0, 4'b0000);
    @(negedge clk);
    excAck[0] = 1'b1;
    pushAck(0, 2);
    @(negedge clk);
    excAck[0] = 1'b0;
    check("edge beats clear", pendOut[0], 4'b0100);
    eretPhase(0, 2, 1'b1, nxt);
    while (nxt >= 0) begin
      ackPhase(0, nxt);
      eretPhase(0, nxt, 1'b1, nxt);
    end

    // Round-robin with 0101 held: three transactions.
    startTxn(1, 4'b0101, nxt);
    for (int t = 0; t < 3; t++) begin
      ackPhase(1, nxt);
      eretPhase(1, nxt, (t == 2), nxt);
    end
    check("rr drained", nxt, 32'hffffffff);

    // Reset during SERVICE abandons the transaction.
    startTxn(0, 4'b0010, nxt);
    ackPhase(0, nxt);
    #2 rstN = 1'b0;
    #1;
    check("async rst ExtIRQ", extIrq[0], 1'b0);
    check("async rst busy", busyOut[0], 1'b0);
    check("async rst pending", pendOut[0], 4'b0);
    check("async rst irq_id", idOut[0], 4'd0);
    check("async rst state", dbg[0], IDLE);
    @(negedge clk);
    driveIrq(0, 4'b0);
    @(negedge clk);
    check("no ack during reset", ackOut[0], 4'b0);
    modelReset();
    rstN = 1'b1;
    repeat (2) @(negedge clk);

    // Randomized traffic on both instances.
    for (int d = 0; d < 2; d++) begin
      nxt = -1;
      repeat (30) begin
        if (nxt < 0) begin
          if ($urandom_range(0, 3) == 0) writeMask(d, 4'($urandom_range(0, 15)), nxt);
          if (nxt < 0) startTxn(d, 4'($urandom_range(1, 15)), nxt);
        end else begin
          ackPhase(d, nxt);
          eretPhase(d, nxt, 1'($urandom_range(0, 1)), nxt);
        end
      end
      guard = 0;
      while (nxt >= 0 && guard < 8) begin
        ackPhase(d, nxt);
        eretPhase(d, nxt, 1'b1, nxt);
        guard++;
      end
    end

    repeat (5) @(negedge clk);
    check("dut0 id queue drained", expId0.size(), 0);
    check("dut1 id queue drained", expId1.size(), 0);
    check("dut0 ack queue drained", expAck0.size(), 0);
    check("dut1 ack queue drained", expAck1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time budget exceeded");
    $fatal(1);
  end

endmodule
